// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and reject-error pulses.
// Optional macro SYNC_FIFO_ERR_EN builds the wr_err/rd_err registers; otherwise both are tied low.
module synchronous_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   data_cnt,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int unsigned             DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]     CNT_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]     CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0]   PTR_ONE   = 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   data_cnt_q, data_cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_acc, rd_acc;

  assign empty = (data_cnt_q == '0);
  assign full  = (data_cnt_q == CNT_FULL);

  // Acceptance uses pre-edge full/empty only: no pass-through when full or empty.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_cnt_d = data_cnt_q;
    rd_data_d  = rd_data_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   data_cnt_d = data_cnt_q + CNT_ONE;
      2'b01:   data_cnt_d = data_cnt_q - CNT_ONE;
      default: data_cnt_d = data_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_cnt_q <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_cnt_q <= data_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign data_cnt = data_cnt_q;

`ifdef SYNC_FIFO_ERR_EN
  logic wr_err_q, wr_err_d;
  logic rd_err_q, rd_err_d;

  always_comb begin
    wr_err_d = wr_en && full;
    rd_err_d = rd_en && empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Scoreboard bench for synchronous_fifo: the driver queues hand-derived expectations per edge,
// a monitor pops and compares them one time unit after each rising edge.
module tb_synchronous_fifo;

  localparam int DW = 8;
  localparam int AW = 3;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty, full;
  logic [AW:0]   data_cnt;
  logic          wr_err, rd_err;

  synchronous_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .data_cnt(data_cnt),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    int rdd;
    bit we;
    bit re;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_id   = 0;

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, id, act, exp);
    end
  endtask

  // One edge of stimulus plus the state expected right after that edge.
  task automatic step(input bit w, input bit r, input int d, input int cnt, input int rdd,
                      input bit we, input bit re);
    exp_t e;
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    wr_data = d[DW-1:0];
    e.id  = vec_id++;
    e.cnt = cnt;
    e.rdd = rdd;
    e.we  = we & ERR_ON;
    e.re  = re & ERR_ON;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"},  -1, int'(empty),    1);
    chk({tag, "_full"},   -1, int'(full),     0);
    chk({tag, "_cnt"},    -1, int'(data_cnt), 0);
    chk({tag, "_rddata"}, -1, int'(rd_data),  0);
    chk({tag, "_wrerr"},  -1, int'(wr_err),   0);
    chk({tag, "_rderr"},  -1, int'(rd_err),   0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cnt",    e.id, int'(data_cnt), e.cnt);
        chk("rddata", e.id, int'(rd_data),  e.rdd);
        chk("empty",  e.id, int'(empty),    int'(e.cnt == 0));
        chk("full",   e.id, int'(full),     int'(e.cnt == 8));
        chk("wrerr",  e.id, int'(wr_err),   int'(e.we));
        chk("rderr",  e.id, int'(rd_err),   int'(e.re));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin : driver
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0..7
    for (int i = 0; i < 8; i++) step(1, 0, i, i + 1, 0, 0, 0);
    // Overflow attempts with 8: rejected, count holds
    for (int i = 0; i < 6; i++) step(1, 0, 8, 8, 0, 1, 0);
    // Drain 0..7 then two underflow attempts holding 7
    for (int i = 0; i < 8; i++) step(0, 1, 0, 7 - i, i, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 7, 0, 1);
    // Load 10..13 to reach count 4 (pointers both at 0)
    for (int i = 0; i < 4; i++) step(1, 0, 10 + i, i + 1, 7, 0, 0);
    // Simultaneous 20..25: write pointer wraps past 7
    for (int i = 0; i < 4; i++) step(1, 1, 20 + i, 4, 10 + i, 0, 0);
    for (int i = 4; i < 6; i++) step(1, 1, 20 + i, 4, 16 + i, 0, 0);
    // Drain 22..25: read pointer wraps past 7
    for (int i = 0; i < 4; i++) step(0, 1, 0, 3 - i, 22 + i, 0, 0);
    // Fill 30..37 to full
    for (int i = 0; i < 8; i++) step(1, 0, 30 + i, i + 1, 25, 0, 0);
    // Both requests when full: read wins, write rejected
    step(1, 1, 99, 7, 30, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 6 - i, 31 + i, 0, 0);
    // Both requests when empty: write wins, read rejected
    step(1, 1, 50, 1, 37, 0, 1);
    step(0, 1, 0, 0, 50, 0, 0);
    // Mid-stream asynchronous reset
    step(1, 0, 60, 1, 50, 0, 0);
    step(1, 0, 61, 2, 50, 0, 0);
    @(negedge clk);
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'd62;
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b1;
    // Post-reset operation resumes from a clean state
    step(1, 0, 70, 1, 0, 0, 0);
    step(0, 1, 0, 0, 70, 0, 0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", -1, exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
